// File: rtl/branch_ctrl_unit.sv
// Execute-stage branch/call/return controller with a hardware return-address stack.
// Resolves branches on latched ALU flags and issues a registered PC redirect to fetch.
module branch_ctrl_unit #(
    parameter int unsigned DEPTH  = 8,
    parameter logic [31:0] VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [4:0]  opcode,
    input  logic [1:0]  cond,
    input  logic [1:0]  alu_flags,
    input  logic [31:0] pc_plus1,
    input  logic [31:0] target,
    input  logic        irq_take,
    input  logic [31:0] irq_ret_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [1:0]  flags_q,
    output logic        stk_empty,
    output logic        stk_full,
    output logic        stk_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [4:0] OpBr   = 5'b00001;
    localparam logic [4:0] OpCmp  = 5'b10010;
    localparam logic [4:0] OpCall = 5'b11001;
    localparam logic [4:0] OpRet  = 5'b11010;
    localparam logic [4:0] OpReti = 5'b11011;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [1:0]    shadow_q, shadow_d;
    logic [1:0]    flags_d;
    logic          redirect_d;
    logic [31:0]   redirect_pc_d;
    logic          err_d;
    logic          push_en;
    logic [31:0]   push_data;
    logic          is_full, is_empty;
    logic [AW-1:0] top_idx;
    logic          flag_n, flag_z, taken;

    always_comb begin
        is_full  = (sp_q == PW'(DEPTH));
        is_empty = (sp_q == '0);
        top_idx  = sp_q[AW-1:0] - AW'(1);
        flag_n   = flags_q[1];
        flag_z   = flags_q[0];
        case (cond)
            2'b00:   taken = flag_z;
            2'b01:   taken = ~flag_z;
            2'b10:   taken = flag_n & ~flag_z;
            default: taken = ~flag_n & ~flag_z;
        endcase
    end

    always_comb begin
        sp_d          = sp_q;
        shadow_d      = shadow_q;
        flags_d       = flags_q;
        redirect_d    = 1'b0;
        redirect_pc_d = 32'h0;
        err_d         = stk_err;
        push_en       = 1'b0;
        push_data     = 32'h0;

        if (irq_take) begin
            // The EX instruction is dropped entirely; the controller replays it.
            redirect_d    = 1'b1;
            redirect_pc_d = VECTOR;
            shadow_d      = flags_q;
            push_data     = irq_ret_pc;
            if (is_full) begin
                err_d = 1'b1;
            end else begin
                push_en = 1'b1;
                sp_d    = sp_q + PW'(1);
            end
        end else if (valid) begin
            case (opcode)
                OpCmp: flags_d = alu_flags;
                OpBr: begin
                    redirect_d    = taken;
                    redirect_pc_d = taken ? target : 32'h0;
                end
                OpCall: begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = target;
                    push_data     = pc_plus1;
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + PW'(1);
                    end
                end
                OpRet, OpReti: begin
                    redirect_d = 1'b1;
                    if (opcode == OpReti) begin
                        flags_d = shadow_q;
                    end
                    if (is_empty) begin
                        err_d         = 1'b1;
                        redirect_pc_d = 32'h0;
                    end else begin
                        redirect_pc_d = mem[top_idx];
                        sp_d          = sp_q - PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q        <= '0;
            shadow_q    <= 2'b00;
            flags_q     <= 2'b00;
            redirect    <= 1'b0;
            redirect_pc <= 32'h0;
            stk_err     <= 1'b0;
            stk_empty   <= 1'b1;
            stk_full    <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            shadow_q    <= shadow_d;
            flags_q     <= flags_d;
            redirect    <= redirect_d;
            redirect_pc <= redirect_pc_d;
            stk_err     <= err_d;
            stk_empty   <= (sp_d == '0);
            stk_full    <= (sp_d == PW'(DEPTH));
        end
    end

    // Stack storage needs no reset; contents are only read below the pointer.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[sp_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Scoreboard bench for branch_ctrl_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_branch_ctrl_unit;

    localparam int unsigned DEPTH  = 8;
    localparam logic [31:0] VECTOR = 32'h0000_0100;

    localparam logic [4:0] OP_BR   = 5'b00001;
    localparam logic [4:0] OP_CMP  = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b11001;
    localparam logic [4:0] OP_RET  = 5'b11010;
    localparam logic [4:0] OP_RETI = 5'b11011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [4:0]  opcode;
    logic [1:0]  cond;
    logic [1:0]  alu_flags;
    logic [31:0] pc_plus1;
    logic [31:0] target;
    logic        irq_take;
    logic [31:0] irq_ret_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  flags_q;
    logic        stk_empty;
    logic        stk_full;
    logic        stk_err;

    branch_ctrl_unit #(.DEPTH(DEPTH), .VECTOR(VECTOR)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode), .cond(cond),
        .alu_flags(alu_flags), .pc_plus1(pc_plus1), .target(target),
        .irq_take(irq_take), .irq_ret_pc(irq_ret_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .flags_q(flags_q), .stk_empty(stk_empty),
        .stk_full(stk_full), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        red;
        logic [31:0] pc;
        logic [1:0]  fl;
        logic        emp;
        logic        ful;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model state
    logic [31:0] m_stack[$];
    logic [1:0]  m_flags;
    logic [1:0]  m_shadow;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stack.delete();
        m_flags  = 2'b00;
        m_shadow = 2'b00;
        m_err    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("redirect", {31'b0, redirect}, {31'b0, e.red});
            if (e.red) chk("redirect_pc", redirect_pc, e.pc);
            chk("flags_q", {30'b0, flags_q}, {30'b0, e.fl});
            chk("stk_empty", {31'b0, stk_empty}, {31'b0, e.emp});
            chk("stk_full", {31'b0, stk_full}, {31'b0, e.ful});
            chk("stk_err", {31'b0, stk_err}, {31'b0, e.err});
        end
    end

    task automatic issue(input logic v, input logic [4:0] op, input logic [1:0] c,
                         input logic [1:0] af, input logic [31:0] p1, input logic [31:0] tg,
                         input logic irq, input logic [31:0] rp);
        exp_t e;
        logic n, z;
        valid = v; opcode = op; cond = c; alu_flags = af;
        pc_plus1 = p1; target = tg; irq_take = irq; irq_ret_pc = rp;
        e.red = 1'b0;
        e.pc  = 32'h0;
        n = m_flags[1];
        z = m_flags[0];
        if (irq) begin
            e.red = 1'b1;
            e.pc  = VECTOR;
            m_shadow = m_flags;
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else m_stack.push_back(rp);
        end else if (v) begin
            if (op == OP_CMP) begin
                m_flags = af;
            end else if (op == OP_BR) begin
                if      (c == 2'd0) e.red = z;
                else if (c == 2'd1) e.red = !z;
                else if (c == 2'd2) e.red = n && !z;
                else                e.red = !n && !z;
                e.pc = tg;
            end else if (op == OP_CALL) begin
                e.red = 1'b1;
                e.pc  = tg;
                if (m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back(p1);
            end else if (op == OP_RET || op == OP_RETI) begin
                e.red = 1'b1;
                if (m_stack.size() == 0) begin
                    m_err = 1'b1;
                    e.pc  = 32'h0;
                end else begin
                    e.pc = m_stack.pop_back();
                end
                if (op == OP_RETI) m_flags = m_shadow;
            end
        end
        e.fl  = m_flags;
        e.emp = (m_stack.size() == 0);
        e.ful = (m_stack.size() == DEPTH);
        e.err = m_err;
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic instr(input logic [4:0] op, input logic [1:0] c, input logic [1:0] af,
                         input logic [31:0] p1, input logic [31:0] tg);
        issue(1'b1, op, c, af, p1, tg, 1'b0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_redirect"}, {31'b0, redirect}, 32'h0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'h0);
        chk({tag, "_flags"}, {30'b0, flags_q}, 32'h0);
        chk({tag, "_empty"}, {31'b0, stk_empty}, 32'h1);
        chk({tag, "_full"}, {31'b0, stk_full}, 32'h0);
        chk({tag, "_err"}, {31'b0, stk_err}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops[7];
        ops = '{OP_BR, OP_CMP, OP_CALL, OP_RET, OP_RETI, 5'b00000, 5'b11111};
        rst_n = 1'b0;
        valid = 1'b0; opcode = 5'h0; cond = 2'b0; alu_flags = 2'b0;
        pc_plus1 = 32'h0; target = 32'h0; irq_take = 1'b0; irq_ret_pc = 32'h0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Branch resolution on freshly latched flags
        instr(OP_CMP, 2'b00, 2'b01, 32'h0, 32'h0);
        instr(OP_BR,  2'b00, 2'b00, 32'h0, 32'h40);
        instr(OP_CMP, 2'b00, 2'b01, 32'h0, 32'h0);
        instr(OP_BR,  2'b01, 2'b00, 32'h0, 32'h40);
        instr(OP_CMP, 2'b00, 2'b10, 32'h0, 32'h0);
        instr(OP_BR,  2'b10, 2'b00, 32'h0, 32'h50);
        instr(OP_BR,  2'b11, 2'b00, 32'h0, 32'h60);
        instr(OP_CMP, 2'b00, 2'b00, 32'h0, 32'h0);
        instr(OP_BR,  2'b11, 2'b00, 32'h0, 32'h70);
        issue(1'b0, OP_BR, 2'b11, 2'b00, 32'h0, 32'h80, 1'b0, 32'h0);

        // Fill, overflow, drain and underflow the return stack
        for (int i = 1; i <= 8; i++) instr(OP_CALL, 2'b00, 2'b00, 32'(i), 32'(32'h1000 + i));
        instr(OP_CALL, 2'b00, 2'b00, 32'h9, 32'h2000);
        for (int i = 0; i < 8; i++) instr(OP_RET, 2'b00, 2'b00, 32'h0, 32'h0);
        instr(OP_RET, 2'b00, 2'b00, 32'h0, 32'h0);

        // Interrupt entry drops the concurrent CMP; RETI restores the shadow flags
        instr(OP_CMP, 2'b00, 2'b01, 32'h0, 32'h0);
        issue(1'b1, OP_CMP, 2'b00, 2'b10, 32'h0, 32'h0, 1'b1, 32'h123);
        instr(OP_CMP, 2'b00, 2'b10, 32'h0, 32'h0);
        instr(OP_RETI, 2'b00, 2'b00, 32'h0, 32'h0);

        // Asynchronous reset asserted between edges while a CALL is presented
        instr(OP_CALL, 2'b00, 2'b00, 32'h33, 32'h44);
        @(negedge clk); #1;
        valid = 1'b1; opcode = OP_CALL; pc_plus1 = 32'h55; target = 32'h66;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        valid = 1'b0; irq_take = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic v, irq;
            v   = ($urandom_range(0, 9) < 8);
            irq = ($urandom_range(0, 15) == 0);
            issue(v, ops[$urandom_range(0, 6)], 2'($urandom), 2'($urandom),
                  $urandom, $urandom, irq, $urandom);
        end

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
